// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Purpose  : Issue stage in front of the 16-bit SimpleALU. Buffers
//            {a, b, config} requests in a small FIFO with a valid/ready
//            handshake on both sides. The head entry is presented directly
//            on the ALU operand/opcode inputs, so producer and consumer
//            stalls are decoupled from each other.
// Ports    : CLK, ASYNCRESET         - clock, asynchronous active-high reset
//            in_valid/in_ready       - producer handshake
//            in_a, in_b, in_config   - request payload
//            a, b, out_config        - head entry, to ALU a/b/config
//            out_valid/out_ready     - consumer handshake
//            count                   - occupancy, 0..DEPTH
//            issued                  - completed pops, modulo 2^CNTW
// Notes    : The ALU opcode output is named out_config because "config"
//            is a reserved word in SystemVerilog.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [1:0]               in_config,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic [1:0]               out_config,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNTW-1:0]          issued
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [CW-1:0]   C_FULL     = CW'(DEPTH);
    // Opcode 3 makes the ALU output zero while the queue is empty.
    localparam logic [1:0]      C_CFG_ZERO = 2'b11;

    // Payload storage; deliberately not reset.
    logic [WIDTH-1:0] r_mem_a   [DEPTH];
    logic [WIDTH-1:0] r_mem_b   [DEPTH];
    logic [1:0]       r_mem_cfg [DEPTH];

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNTW-1:0]  r_issued;

    logic             w_nonempty;
    logic             w_can_accept;
    logic             w_push;
    logic             w_pop;

    assign w_nonempty   = (r_count != '0);
    // in_ready depends only on the registered count, so a pop in the same
    // cycle cannot re-open a full queue (no pass-through).
    assign w_can_accept = ~ASYNCRESET & (r_count != C_FULL);
    assign w_push       = in_valid & w_can_accept;
    assign w_pop        = out_ready & w_nonempty;

    // Pointers, occupancy and issue counter.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_issued <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_issued <= r_issued + CNTW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload write port.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= in_a;
            r_mem_b[r_wr_ptr]   <= in_b;
            r_mem_cfg[r_wr_ptr] <= in_config;
        end
    end

    // Head presentation: registered entry when non-empty, ALU-zeroing
    // pattern otherwise. r_count clears asynchronously, so this also covers
    // the reset window without a clock edge.
    assign a          = w_nonempty ? r_mem_a[r_rd_ptr]   : '0;
    assign b          = w_nonempty ? r_mem_b[r_rd_ptr]   : '0;
    assign out_config = w_nonempty ? r_mem_cfg[r_rd_ptr] : C_CFG_ZERO;

    assign out_valid  = w_nonempty;
    assign in_ready   = w_can_accept;
    assign count      = r_count;
    assign issued     = r_issued;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_queue
// Purpose  : Self-checking bench for alu_issue_queue. A queue-based model
//            of the issue stage predicts every output after each clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;

    logic              CLK;
    logic              ASYNCRESET;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [1:0]        in_config;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [1:0]        out_config;
    logic              out_valid;
    logic              out_ready;
    logic [$clog2(DEPTH):0] count;
    logic [CNTW-1:0]   issued;

    alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_config  (in_config),
        .a          (a),
        .b          (b),
        .out_config (out_config),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .issued     (issued)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: queue of {a, b, config} in push order.
    logic [33:0] mq[$];
    int          m_issued;
    bit          m_in_rst;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                            input logic [1:0] op);
        logic [31:0] prod;
        prod = x * y;
        case (op)
            2'd0:    return x + y;
            2'd1:    return x - y;
            2'd2:    return prod[15:0];
            default: return 16'h0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [33:0] h;
        h = (mq.size() != 0) ? mq[0] : {16'h0, 16'h0, 2'b11};
        chk({tag, ".count"},     32'(count),      32'(mq.size()));
        chk({tag, ".out_valid"}, 32'(out_valid),  32'(mq.size() != 0));
        chk({tag, ".in_ready"},  32'(in_ready),   32'(!m_in_rst && mq.size() != DEPTH));
        chk({tag, ".a"},         32'(a),          32'(h[33:18]));
        chk({tag, ".b"},         32'(b),          32'(h[17:2]));
        chk({tag, ".config"},    32'(out_config), 32'(h[1:0]));
        chk({tag, ".issued"},    32'(issued),     32'(m_issued % (1 << CNTW)));
    endtask

    // Called at posedge+1: drives inputs, clocks once, updates the model
    // and checks at the next posedge+1.
    task automatic step(input string tag, input logic v, input logic [15:0] ia,
                        input logic [15:0] ib, input logic [1:0] ic, input logic ordy);
        bit do_push, do_pop;
        in_valid  = v;
        in_a      = ia;
        in_b      = ib;
        in_config = ic;
        out_ready = ordy;
        do_push = v && (mq.size() != DEPTH);
        do_pop  = ordy && (mq.size() != 0);
        @(posedge CLK);
        if (do_pop) begin
            void'(mq.pop_front());
            m_issued++;
        end
        if (do_push) mq.push_back({ia, ib, ic});
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_issued = 0;
    endtask

    initial begin
        logic [15:0] fa [4];
        logic [15:0] fb [4];
        logic [1:0]  fc [4];
        logic [15:0] fexp [4];
        fa = '{16'd1, 16'd7, 16'd3, 16'd9};
        fb = '{16'd1, 16'd2, 16'd4, 16'd9};
        fc = '{2'd0, 2'd1, 2'd2, 2'd3};
        fexp = '{16'd2, 16'd5, 16'd12, 16'd0};

        ASYNCRESET = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_config  = '0;
        out_ready  = 1'b0;
        m_in_rst   = 1'b0;
        model_reset();

        // Reset asserted mid-cycle: outputs clear without a clock edge.
        #2 ASYNCRESET = 1'b1;
        m_in_rst = 1'b1;
        #1 check_all("reset_async");
        @(posedge CLK);
        #1 check_all("reset_held");
        #2 ASYNCRESET = 1'b0;
        m_in_rst = 1'b0;
        #1 check_all("reset_release");
        @(posedge CLK);
        #1 check_all("idle");

        // Single op.
        step("single_push", 1'b1, 16'h0005, 16'h0003, 2'd0, 1'b0);
        chk("single_alu_c", 32'(alu_ref(a, b, out_config)), 32'h0008);
        step("single_pop", 1'b0, 16'h0, 16'h0, 2'd0, 1'b1);
        step("pop_empty", 1'b0, 16'h0, 16'h0, 2'd0, 1'b1);

        // Fill and stall, then an ignored fifth request.
        for (int i = 0; i < 4; i++) step("fill", 1'b1, fa[i], fb[i], fc[i], 1'b0);
        step("fifth_ignored", 1'b1, 16'hAAAA, 16'h5555, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_alu_c", 32'(alu_ref(a, b, out_config)), 32'(fexp[i]));
            step("drain", 1'b0, 16'h0, 16'h0, 2'd0, 1'b1);
        end

        // Concurrent traffic at count = 2 across pointer wrap.
        step("conc_pre", 1'b1, 16'h1111, 16'h2222, 2'd2, 1'b0);
        step("conc_pre", 1'b1, 16'h3333, 16'h4444, 2'd1, 1'b0);
        for (int i = 0; i < 10; i++)
            step("conc", 1'b1, 16'($urandom), 16'($urandom), 2'($urandom), 1'b1);
        chk("conc_count", 32'(count), 32'd2);
        chk("conc_issued", 32'(issued), 32'd15);

        // Full plus pop: only the pop happens.
        step("full_fill", 1'b1, 16'h0A0A, 16'h0B0B, 2'd0, 1'b0);
        step("full_fill", 1'b1, 16'h0C0C, 16'h0D0D, 2'd1, 1'b0);
        step("full_pop", 1'b1, 16'hDEAD, 16'hBEEF, 2'd2, 1'b1);
        chk("full_pop_count", 32'(count), 32'd3);

        // Reset mid-operation with count = 3.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 ASYNCRESET = 1'b1;
        m_in_rst = 1'b1;
        model_reset();
        #1 check_all("midreset");
        #2 ASYNCRESET = 1'b0;
        m_in_rst = 1'b0;
        #1 check_all("midreset_release");
        @(posedge CLK);
        #1;
        step("post_push", 1'b1, 16'h0005, 16'h0003, 2'd0, 1'b0);
        step("post_pop", 1'b0, 16'h0, 16'h0, 2'd0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 2'($urandom), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
